load_writeback_unit: RTL and testbench

Writeback-side load unit for the uPower datapath. It sits between the ALU/effective-address stage and the 64-bit register file write port. It accepts one instruction at a time, performs the data-memory read for loads through a ready/valid handshake, and zero- or sign-extends the returned data per opcode. It then presents `write_data`, the destination register and a one-cycle `RegWrite` pulse to the register file. Non-load results bypass memory and are written back directly.

---
 rtl/load_writeback_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_writeback_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: writeback-side load unit.
// Accepts one instruction at a time. Loads read data memory over a req/ready
// handshake and zero- or sign-extend the returned data. Non-loads forward
// alu_result. Every output is driven directly from a flop.
module load_writeback_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [63:0] ea,
  input  logic [63:0] alu_result,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic [63:0] write_data,
  output logic [4:0]  wb_rd,
  output logic        RegWrite,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LD  = 6'd58;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc_s;
  logic [5:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           req_ready_q, req_ready_d;
  logic           mem_req_q, mem_req_d;
  logic [63:0]    mem_addr_q, mem_addr_d;
  logic [63:0]    write_data_q, write_data_d;
  logic [4:0]     wb_rd_q, wb_rd_d;
  logic           reg_write_q, reg_write_d;
  logic           err_q, err_d;

  // Recognised load opcodes; everything else is a non-load.
  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LBZ, OP_LHZ, OP_LHA, OP_LWZ, OP_LD: is_load = 1'b1;
      default:                               is_load = 1'b0;
    endcase
  endfunction

  // Natural alignment check: the address must be a multiple of the access size.
  function automatic logic is_aligned(input logic [5:0] op, input logic [63:0] addr);
    case (op)
      OP_LBZ:         is_aligned = 1'b1;
      OP_LHZ, OP_LHA: is_aligned = (addr[0] == 1'b0);
      OP_LWZ:         is_aligned = (addr[1:0] == 2'b00);
      OP_LD:          is_aligned = (addr[2:0] == 3'b000);
      default:        is_aligned = 1'b1;
    endcase
  endfunction

  // Zero/sign extension of right-justified memory data. Only lha sign-extends.
  function automatic logic [63:0] extend(input logic [5:0] op, input logic [63:0] d);
    case (op)
      OP_LBZ:  extend = {56'd0, d[7:0]};
      OP_LHZ:  extend = {48'd0, d[15:0]};
      OP_LHA:  extend = {{48{d[15]}}, d[15:0]};
      OP_LWZ:  extend = {32'd0, d[31:0]};
      OP_LD:   extend = d;
      default: extend = d;
    endcase
  endfunction

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign write_data = write_data_q;
  assign wb_rd      = wb_rd_q;
  assign RegWrite   = reg_write_q;
  assign err        = err_q;

  // Next-state and next-output logic; strobes default low, data holds.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rd_d         = rd_q;
    req_ready_d  = req_ready_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    write_data_d = write_data_q;
    wb_rd_d      = wb_rd_q;
    reg_write_d  = 1'b0;
    err_d        = 1'b0;
    cnt_inc_s    = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d  = opcode;
          rd_d  = rd;
          cnt_d = '0;
          if (!is_load(opcode)) begin
            state_d      = WRITEBACK;
            write_data_d = alu_result;
            wb_rd_d      = rd;
            reg_write_d  = 1'b1;
            req_ready_d  = 1'b0;
          end else if (!is_aligned(opcode, ea)) begin
            // Misaligned: flag it and stay ready for the next request.
            err_d = 1'b1;
          end else begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_addr_d  = ea;
            req_ready_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      MEM_WAIT: begin
        cnt_d = cnt_inc_s;
        // mem_ready has priority over a timeout in the same cycle.
        if (mem_ready) begin
          state_d      = WRITEBACK;
          write_data_d = extend(op_q, mem_rdata);
          wb_rd_d      = rd_q;
          reg_write_d  = 1'b1;
          mem_req_d    = 1'b0;
          cnt_d        = '0;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          err_d       = 1'b1;
          req_ready_d = 1'b1;
          cnt_d       = '0;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      WRITEBACK: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= 6'd0;
      rd_q         <= 5'd0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 64'd0;
      write_data_q <= 64'd0;
      wb_rd_q      <= 5'd0;
      reg_write_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
      wb_rd_q      <= wb_rd_d;
      reg_write_q  <= reg_write_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Scoreboard bench for load_writeback_unit: the driver pushes expected
// writebacks/errors, and an independent monitor pops them when RegWrite or err fires.
module tb_load_writeback_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [63:0] ea;
  logic [63:0] alu_result;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [63:0] write_data;
  logic [4:0]  wb_rd;
  logic        RegWrite;
  logic        err;

  load_writeback_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .rd(rd), .ea(ea), .alu_result(alu_result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .write_data(write_data), .wb_rd(wb_rd),
    .RegWrite(RegWrite), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, expv);
    end
  endtask

  // Reference model: access size in bytes, 0 for a non-load.
  function automatic int acc_size(input logic [5:0] op);
    case (op)
      6'd34: return 1;
      6'd40: return 2;
      6'd42: return 2;
      6'd32: return 4;
      6'd58: return 8;
      default: return 0;
    endcase
  endfunction

  // Reference model: value the register file should receive for a load.
  function automatic logic [63:0] ref_load(input logic [5:0] op, input logic [63:0] d);
    longint v;
    case (op)
      6'd34: v = longint'(d & 64'h0000_0000_0000_00FF);
      6'd40: v = longint'(d & 64'h0000_0000_0000_FFFF);
      6'd42: v = longint'(shortint'(d[15:0]));
      6'd32: v = longint'(d & 64'h0000_0000_FFFF_FFFF);
      default: v = longint'(d);
    endcase
    return 64'(v);
  endfunction

  // Monitor: every RegWrite or err cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && (RegWrite === 1'b1 || err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {62'd0, RegWrite, err}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_err",   {63'd0, err},      {63'd0, e.is_err});
        chk("event_write", {63'd0, RegWrite}, {63'd0, !e.is_err});
        if (!e.is_err) begin
          chk("wb_rd",      {59'd0, wb_rd}, {59'd0, e.rd});
          chk("write_data", write_data,     e.data);
        end
      end
    end
  end

  // Issue one instruction and act as the memory. wait_cycles = cycles of
  // mem_req before mem_ready; no_resp never answers (timeout).
  task automatic do_req(input logic [5:0] op, input logic [4:0] r, input logic [63:0] a,
                        input logic [63:0] alu, input logic [63:0] md,
                        input int wait_cycles, input bit no_resp);
    int   sz;
    bit   misal;
    bit   writes;
    int   reqs;
    int   exp_reqs;
    int   guard;
    exp_t e;
    sz    = acc_size(op);
    misal = (sz != 0) && ((a % 64'(sz)) != 64'd0);
    if (sz == 0) begin
      e = '{is_err: 1'b0, rd: r, data: alu};
      exp_reqs = 0;
    end else if (misal) begin
      e = '{is_err: 1'b1, rd: r, data: 64'd0};
      exp_reqs = 0;
    end else if (no_resp) begin
      e = '{is_err: 1'b1, rd: r, data: 64'd0};
      exp_reqs = TO;
    end else begin
      e = '{is_err: 1'b0, rd: r, data: ref_load(op, md)};
      exp_reqs = wait_cycles + 1;
    end
    writes = !e.is_err;

    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    opcode     = op;
    rd         = r;
    ea         = a;
    alu_result = alu;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    opcode     = 6'($urandom);
    ea         = {$urandom, $urandom};
    alu_result = {$urandom, $urandom};

    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req !== 1'b1) break;
      reqs++;
      chk("mem_addr_stable", mem_addr, a);
      if (!no_resp && reqs == wait_cycles + 1) begin
        mem_ready = 1'b1;
        mem_rdata = md;
      end
    end
    mem_ready = 1'b0;
    chk("mem_req_cycles", 64'(reqs), 64'(exp_reqs));
    chk("ready_after", {63'd0, req_ready}, {63'd0, !writes});
  endtask

  logic [63:0] pat;
  logic [5:0]  ops[8];

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    opcode     = 6'd0;
    rd         = 5'd0;
    ea         = 64'd0;
    alu_result = 64'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 64'd0;
    ops = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd58, 6'd31, 6'd0, 6'd63};

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready",  {63'd0, req_ready}, 64'd1);
    chk("rst_mem_req",    {63'd0, mem_req},   64'd0);
    chk("rst_mem_addr",   mem_addr,           64'd0);
    chk("rst_write_data", write_data,         64'd0);
    chk("rst_wb_rd",      {59'd0, wb_rd},     64'd0);
    chk("rst_regwrite",   {63'd0, RegWrite},  64'd0);
    chk("rst_err",        {63'd0, err},       64'd0);
    mon_en = 1'b1;

    // Non-load.
    do_req(6'd31, 5'd5, 64'h0, 64'h1234, 64'h0, 0, 1'b0);

    // Load extensions, 3 wait cycles before data.
    pat = 64'hFFFF_FFFF_FFFF_8081;
    do_req(6'd34, 5'd1, 64'h1000, 64'h0, pat, 3, 1'b0);
    do_req(6'd40, 5'd2, 64'h1002, 64'h0, pat, 3, 1'b0);
    do_req(6'd42, 5'd3, 64'h1004, 64'h0, pat, 3, 1'b0);
    do_req(6'd32, 5'd4, 64'h1008, 64'h0, pat, 3, 1'b0);
    do_req(6'd58, 5'd0, 64'h1010, 64'h0, pat, 3, 1'b0);

    // Misaligned.
    do_req(6'd32, 5'd6, 64'h102, 64'h0, pat, 0, 1'b0);
    do_req(6'd58, 5'd7, 64'h104, 64'h0, pat, 0, 1'b0);

    // Timeout, then mem_ready on the TIMEOUT-th cycle.
    do_req(6'd58, 5'd8, 64'h2000, 64'h0, pat, 0, 1'b1);
    do_req(6'd58, 5'd9, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, TO - 1, 1'b0);

    // Reset during MEM_WAIT.
    @(negedge clk);
    req_valid = 1'b1; opcode = 6'd58; rd = 5'd10; ea = 64'h3000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mw_mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mw_mem_req",  {63'd0, mem_req},  64'd0);
    chk("rst_mw_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_mw_err",      {63'd0, err},      64'd0);
    rst = 1'b0;
    do_req(6'd31, 5'd11, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      logic [5:0]  op;
      logic [63:0] a;
      op = ops[$urandom_range(7)];
      a  = {$urandom, $urandom};
      if ($urandom_range(1) == 0) a[2:0] = 3'd0;
      do_req(op, 5'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(TO - 1), ($urandom_range(9) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
